// File: rtl/ifu_mw.sv
// ---------------------------------------------------------------------------
// ifu_mw -- multi-wide instruction fetch unit
//
// Fetches aligned groups of FETCH_WIDTH instructions from the icache and
// keeps at most one request in flight. It predicts the next fetch address
// (JAL always taken; conditional branches via the optional BTFN predictor)
// and pushes the useful slots of each group into an instruction FIFO, which
// dispatch drains one entry per cycle. A backend redirect flushes the FIFO
// and restarts fetch at the new PC.
//
// Optional feature macro: IFU_BTFN_PRED_EN
//   defined   : conditional branches with a negative offset predicted taken
//   undefined : all conditional branches predicted not taken
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fetch_redirect_valid/PC  backend redirect and its target
//   icache_req_valid/addr    group fetch request (address group-aligned)
//   icache_req_ready         icache accepts the request
//   icache_resp_valid/data   group data, slot i = data[32i+31:32i]
//   ififo_dispatch_valid     FIFO head valid
//   ififo_dispatch_ready     dispatch takes the head
//   ififo_dispatch_data      {instr, pc, is_cond_br, br_dir_pred, br_target_pred}
//   ififo_count              occupied FIFO entries
// ---------------------------------------------------------------------------
`ifndef IFIFO_ENTRY_WIDTH
`define IFIFO_ENTRY_WIDTH 98
`endif

module ifu_mw #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          IFIFO_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_redirect_valid,
  input  logic [31:0]                   fetch_redirect_PC,
  output logic                          icache_req_valid,
  output logic [31:0]                   icache_req_addr,
  input  logic                          icache_req_ready,
  input  logic                          icache_resp_valid,
  input  logic [32*FETCH_WIDTH-1:0]     icache_resp_data,
  output logic                          ififo_dispatch_valid,
  input  logic                          ififo_dispatch_ready,
  output logic [`IFIFO_ENTRY_WIDTH-1:0] ififo_dispatch_data,
  output logic [$clog2(IFIFO_DEPTH):0]  ififo_count
);

  localparam int          PTR_W       = $clog2(IFIFO_DEPTH);
  localparam int          CNT_W       = PTR_W + 1;
  localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [31:0] OFF_MASK    = GROUP_BYTES - 32'd1;

  typedef logic [`IFIFO_ENTRY_WIDTH-1:0] entry_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;

  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  entry_t             mem [IFIFO_DEPTH];

  logic [31:0]            group_base;
  int                     start_slot;
  int                     end_slot;
  logic [31:0]            next_fetch_pc;
  logic [FETCH_WIDTH-1:0] slot_taken;
  logic [31:0]            slot_target [FETCH_WIDTH];
  entry_t                 slot_entry  [FETCH_WIDTH];

  logic               free_ok;
  logic               resp_accept;
  logic               deq;
  logic [CNT_W-1:0]   enq_num;
  logic [CNT_W-1:0]   enq_add;

  assign group_base = pc_reg & ~OFF_MASK;

  // ---------------------------------------------------------------------
  // Per-slot decode and prediction
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
    logic [31:0] instr;
    logic [31:0] slot_pc;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        is_jal;
    logic        is_cond;
    logic        dir_pred;

    assign instr   = icache_resp_data[32*gi +: 32];
    assign slot_pc = group_base + 32'(4 * gi);
    assign is_jal  = (instr[6:0] == 7'b1101111);
    assign is_cond = (instr[6:0] == 7'b1100011);
    assign j_imm   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign b_imm   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

`ifdef IFU_BTFN_PRED_EN
    // Backward branches (sign bit of the offset set) are predicted taken.
    assign dir_pred = is_cond & instr[31];
`else
    assign dir_pred = 1'b0;
`endif

    assign slot_taken[gi]  = is_jal | dir_pred;
    assign slot_target[gi] = slot_pc + (is_jal ? j_imm : b_imm);

    // The slot that ends the group points at the predicted next PC; any
    // earlier slot falls through.
    assign slot_entry[gi] = {instr, slot_pc, is_cond, dir_pred,
                             (gi == end_slot) ? next_fetch_pc : slot_pc + 32'd4};
  end

  // ---------------------------------------------------------------------
  // Group boundaries: first useful slot from the fetch PC, last useful slot
  // is the first predicted-taken one at or after it.
  // ---------------------------------------------------------------------
  always_comb begin
    start_slot    = int'((pc_reg & OFF_MASK) >> 2);
    end_slot      = FETCH_WIDTH - 1;
    next_fetch_pc = group_base + GROUP_BYTES;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      // Scanning downwards leaves the lowest qualifying slot as the winner.
      if (i >= start_slot && slot_taken[i]) begin
        end_slot      = i;
        next_fetch_pc = slot_target[i];
      end
    end
  end

  assign enq_num     = CNT_W'(end_slot - start_slot + 1);
  assign free_ok     = (count_reg <= CNT_W'(IFIFO_DEPTH - FETCH_WIDTH));
  assign resp_accept = (state_reg == WAIT) && icache_resp_valid && !fetch_redirect_valid;
  assign enq_add     = resp_accept ? enq_num : '0;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (fetch_redirect_valid) begin
      pc_next = fetch_redirect_PC;
    end else if (resp_accept) begin
      pc_next = next_fetch_pc;
    end

    case (state_reg)
      IDLE:  state_next = REQ;
      REQ: begin
        if (icache_req_valid && icache_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (icache_resp_valid)         state_next = REQ;
        else if (fetch_redirect_valid) state_next = DRAIN;
      end
      // The stale response retires the outstanding request; a redirect
      // landing on the same cycle only updates the PC, so fetch cannot
      // stall waiting for a response that will never come.
      DRAIN: begin
        if (icache_resp_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. A request is withheld during a redirect so an accepted
  // request never carries a stale address.
  // ---------------------------------------------------------------------
  always_comb begin
    icache_req_valid = 1'b0;
    if (state_reg == REQ && free_ok && !fetch_redirect_valid) begin
      icache_req_valid = 1'b1;
    end
  end

  assign icache_req_addr = group_base;

  // ---------------------------------------------------------------------
  // Instruction FIFO. Several entries may be written per cycle, so the
  // storage is a register file with an asynchronous head read.
  // ---------------------------------------------------------------------
  assign ififo_dispatch_valid = (count_reg != '0) && !fetch_redirect_valid;
  assign deq                  = ififo_dispatch_valid && ififo_dispatch_ready;
  assign ififo_dispatch_data  = mem[rd_ptr_reg];
  assign ififo_count          = count_reg;

  always_ff @(posedge clk) begin
    if (rst || fetch_redirect_valid) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (resp_accept) wr_ptr_reg <= wr_ptr_reg + PTR_W'(enq_num);
      if (deq)         rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + enq_add - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && resp_accept) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (i >= start_slot && i <= end_slot) begin
          mem[wr_ptr_reg + PTR_W'(i - start_slot)] <= slot_entry[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_mw.sv
// ---------------------------------------------------------------------------
// tb_ifu_mw -- directed plus randomized bench for ifu_mw (FETCH_WIDTH=2,
// IFIFO_DEPTH=8, RESET_PC=0). Expected FIFO contents and fetch addresses come
// from a behavioural model: a queue of expected entries and the model PC.
// ---------------------------------------------------------------------------
`ifndef IFIFO_ENTRY_WIDTH
`define IFIFO_ENTRY_WIDTH 98
`endif

module tb_ifu_mw;
  localparam int          FW    = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] GROUP = 32'(FW * 4);
  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00208113;
  localparam logic [31:0] JAL16 = 32'h010000EF;
  localparam logic [31:0] JAL8  = 32'h0080006F;
  localparam logic [31:0] BNEM8 = 32'hFE209CE3;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          fetch_redirect_valid;
  logic [31:0]                   fetch_redirect_PC;
  logic                          icache_req_valid;
  logic [31:0]                   icache_req_addr;
  logic                          icache_req_ready;
  logic                          icache_resp_valid;
  logic [32*FW-1:0]              icache_resp_data;
  logic                          ififo_dispatch_valid;
  logic                          ififo_dispatch_ready;
  logic [`IFIFO_ENTRY_WIDTH-1:0] ififo_dispatch_data;
  logic [$clog2(DEPTH):0]        ififo_count;

  ifu_mw #(.FETCH_WIDTH(FW), .IFIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .fetch_redirect_valid (fetch_redirect_valid),
    .fetch_redirect_PC    (fetch_redirect_PC),
    .icache_req_valid     (icache_req_valid),
    .icache_req_addr      (icache_req_addr),
    .icache_req_ready     (icache_req_ready),
    .icache_resp_valid    (icache_resp_valid),
    .icache_resp_data     (icache_resp_data),
    .ififo_dispatch_valid (ififo_dispatch_valid),
    .ififo_dispatch_ready (ififo_dispatch_ready),
    .ififo_dispatch_data  (ififo_dispatch_data),
    .ififo_count          (ififo_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [`IFIFO_ENTRY_WIDTH-1:0] exp_q [$];
  logic [31:0]                   exp_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: append the useful slots of a group fetched at exp_pc
  // and advance exp_pc to the predicted next fetch address.
  task automatic model_fetch(input logic [32*FW-1:0] data);
    logic [31:0] base, npc, w, imm, pcs;
    logic        cond, dir, taken;
    int          s;
    base = exp_pc & ~(GROUP - 32'd1);
    s    = int'((exp_pc - base) / 32'd4);
    npc  = base + GROUP;
    for (int i = s; i < FW; i++) begin
      w    = data[32*i +: 32];
      pcs  = base + 32'(4 * i);
      cond = (w[6:0] == 7'h63);
      dir  = 1'b0;
`ifdef IFU_BTFN_PRED_EN
      if (cond) dir = w[31];
`endif
      taken = (w[6:0] == 7'h6F) || dir;
      if (w[6:0] == 7'h6F) imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      else                 imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      if (taken) begin
        npc = pcs + imm;
        exp_q.push_back({w, pcs, cond, dir, npc});
        break;
      end
      exp_q.push_back({w, pcs, cond, dir, pcs + 32'd4});
    end
    exp_pc = npc;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {r[31:7], 7'h13};
      1:       return {r[31:7], 7'h6F};
      2:       return {r[31:7], 7'h63};
      default: return {r[31:7], 7'h33};
    endcase
  endfunction

  task automatic wait_req();
    int guard = 0;
    while (icache_req_valid !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("req_valid", 128'(icache_req_valid), 128'(1'b1));
  endtask

  // One complete fetch: handshake, lat cycles of latency, response.
  task automatic do_fetch(input logic [32*FW-1:0] data, input int lat, input bit deq_same);
    bit popped = 1'b0;
    wait_req();
    chk("req_addr", 128'(icache_req_addr), 128'(exp_pc & ~(GROUP - 32'd1)));
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    chk("wait_req_low", 128'(icache_req_valid), 128'(1'b0));
    repeat (lat - 1) tick();
    icache_resp_valid = 1'b1;
    icache_resp_data  = data;
    if (deq_same && exp_q.size() > 0) begin
      ififo_dispatch_ready = 1'b1;
      #1;
      chk("deq_head", 128'(ififo_dispatch_data), 128'(exp_q[0]));
      popped = 1'b1;
    end
    tick();
    icache_resp_valid    = 1'b0;
    ififo_dispatch_ready = 1'b0;
    if (popped) void'(exp_q.pop_front());
    model_fetch(data);
    chk("fetch_count", 128'(ififo_count), 128'(exp_q.size()));
    $display("fetch data=%h lat=%0d deq=%0d count=%0d next_pc=%h",
             data, lat, popped, ififo_count, exp_pc);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      ififo_dispatch_ready = 1'b1;
      #1;
      chk("disp_valid", 128'(ififo_dispatch_valid), 128'(1'b1));
      chk("disp_data", 128'(ififo_dispatch_data), 128'(exp_q[0]));
      $display("dispatch entry=%h", ififo_dispatch_data);
      tick();
      void'(exp_q.pop_front());
    end
    ififo_dispatch_ready = 1'b0;
    chk("drain_count", 128'(ififo_count), 128'(exp_q.size()));
  endtask

  task automatic redirect(input logic [31:0] pc);
    fetch_redirect_valid = 1'b1;
    fetch_redirect_PC    = pc;
    #1;
    chk("redir_disp_valid", 128'(ififo_dispatch_valid), 128'(1'b0));
    tick();
    fetch_redirect_valid = 1'b0;
    exp_q.delete();
    exp_pc = pc;
    chk("redir_count", 128'(ififo_count), 128'(0));
    $display("redirect pc=%h", pc);
  endtask

  initial begin
    rst                  = 1'b1;
    fetch_redirect_valid = 1'b0;
    fetch_redirect_PC    = '0;
    icache_req_ready     = 1'b0;
    icache_resp_valid    = 1'b0;
    icache_resp_data     = '0;
    ififo_dispatch_ready = 1'b0;
    exp_pc               = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_count", 128'(ififo_count), 128'(0));
    chk("rst_req_valid", 128'(icache_req_valid), 128'(1'b0));
    chk("rst_disp_valid", 128'(ififo_dispatch_valid), 128'(1'b0));

    // One IDLE cycle after release; a response seen there is ignored.
    rst               = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = {ADDI, ADDI2};
    #1;
    chk("idle_req_valid", 128'(icache_req_valid), 128'(1'b0));
    tick();
    icache_resp_valid = 1'b0;
    chk("first_req_valid", 128'(icache_req_valid), 128'(1'b1));
    chk("first_req_addr", 128'(icache_req_addr), 128'(32'h0));
    chk("idle_resp_ignored", 128'(ififo_count), 128'(0));

    // Start slot 1: slot 0 dropped
    redirect(32'h4);
    do_fetch({ADDI2, ADDI}, 1, 1'b0);
    chk("s1_count", 128'(ififo_count), 128'(1));
    chk("s1_pc", 128'(ififo_dispatch_data[65:34]), 128'(32'h4));
    chk("s1_next_addr", 128'(icache_req_addr), 128'(32'h8));
    drain(1);

    // JAL +16 at 0x10 ends the group
    redirect(32'h10);
    do_fetch({ADDI, JAL16}, 2, 1'b0);
    chk("jal_count", 128'(ififo_count), 128'(1));
    chk("jal_target", 128'(ififo_dispatch_data[31:0]), 128'(32'h20));
    chk("jal_next_addr", 128'(icache_req_addr), 128'(32'h20));
    do_fetch({ADDI2, ADDI}, 1, 1'b0);

    // Redirect while WAIT: flush, drop the stale response, refetch at 0x100
    wait_req();
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready     = 1'b0;
    fetch_redirect_valid = 1'b1;
    fetch_redirect_PC    = 32'h100;
    #1;
    chk("wr_disp_valid", 128'(ififo_dispatch_valid), 128'(1'b0));
    tick();
    fetch_redirect_valid = 1'b0;
    chk("wr_flush_count", 128'(ififo_count), 128'(0));
    chk("wr_drain_req", 128'(icache_req_valid), 128'(1'b0));
    icache_resp_valid = 1'b1;
    icache_resp_data  = {ADDI, ADDI2};
    tick();
    icache_resp_valid = 1'b0;
    chk("wr_resp_dropped", 128'(ififo_count), 128'(0));
    chk("wr_req_valid", 128'(icache_req_valid), 128'(1'b1));
    chk("wr_req_addr", 128'(icache_req_addr), 128'(32'h100));
    exp_q.delete();
    exp_pc = 32'h100;
    $display("redirect-in-wait pc=%h", exp_pc);

    // Fill to 7 entries: requests held until one dequeue leaves 6
    redirect(32'h200);
    do_fetch({ADDI2, ADDI}, 1, 1'b0);
    do_fetch({ADDI2, ADDI}, 1, 1'b0);
    do_fetch({JAL8, ADDI}, 1, 1'b0);
    do_fetch({ADDI2, ADDI}, 1, 1'b0);
    chk("full_count", 128'(ififo_count), 128'(7));
    for (int k = 0; k < 3; k++) begin
      chk("full_req_low", 128'(icache_req_valid), 128'(1'b0));
      tick();
    end
    drain(1);
    chk("free_req_valid", 128'(icache_req_valid), 128'(1'b1));
    chk("free_req_addr", 128'(icache_req_addr), 128'(32'h220));
    drain(exp_q.size());

    // BNE -8 at 0x40
    redirect(32'h40);
    do_fetch({ADDI, BNEM8}, 1, 1'b0);
`ifdef IFU_BTFN_PRED_EN
    chk("bne_next_addr", 128'(icache_req_addr), 128'(32'h38));
    chk("bne_count", 128'(ififo_count), 128'(1));
`else
    chk("bne_next_addr", 128'(icache_req_addr), 128'(32'h48));
    chk("bne_count", 128'(ififo_count), 128'(2));
`endif
    drain(exp_q.size());

    // PC wrap past the top of the address space
    redirect(32'hFFFF_FFFC);
    do_fetch({ADDI2, ADDI}, 1, 1'b0);
    chk("wrap_next_addr", 128'(icache_req_addr), 128'(32'h0));
    drain(exp_q.size());

    // Reset during WAIT abandons the request
    wait_req();
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req_low", 128'(icache_req_valid), 128'(1'b0));
    icache_resp_valid = 1'b1;
    icache_resp_data  = {ADDI, ADDI2};
    tick();
    icache_resp_valid = 1'b0;
    chk("rw_count", 128'(ififo_count), 128'(0));
    chk("rw_req_valid", 128'(icache_req_valid), 128'(1'b1));
    chk("rw_req_addr", 128'(icache_req_addr), 128'(32'h0));
    exp_q.delete();
    exp_pc = 32'h0;
    $display("reset-in-wait");

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) redirect(32'hFFFF_FFF8 | 32'($urandom_range(0, 1) * 4));
        else                           redirect($urandom & 32'hFFFF_FFFC);
      end
      if (exp_q.size() > DEPTH - FW)
        drain(exp_q.size() - (DEPTH - FW) + $urandom_range(0, 2));
      do_fetch({gen_instr(), gen_instr()}, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
    drain(exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_mw.md
IFU_MW -- requirements
Module: ifu_mw

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, meaning instructions per fetch group; legal values are 1, 2 and 4.
REQ-002 Parameter IFIFO_DEPTH, default 8, meaning instruction FIFO entries; it SHALL be a power of 2 and at least FETCH_WIDTH.
REQ-003 Parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 fetch_redirect_valid  in  1  backend redirect.
REQ-007 fetch_redirect_PC  in  32  redirect target.
REQ-008 icache_req_valid  out  1  fetch request.
REQ-009 icache_req_addr  out  32  aligned group address, i.e. PC with the low log2(FETCH_WIDTH*4) bits cleared.
REQ-010 icache_req_ready  in  1  icache accepts the request.
REQ-011 icache_resp_valid  in  1  group data is valid; arrives one or more cycles after acceptance.
REQ-012 icache_resp_data  in  32*FETCH_WIDTH  group data; slot i is bits [32i+31:32i].
REQ-013 ififo_dispatch_valid  out  1  FIFO head is valid.
REQ-014 ififo_dispatch_ready  in  1  dispatch takes the head.
REQ-015 ififo_dispatch_data  out  `IFIFO_ENTRY_WIDTH  entry {instr, pc, is_cond_br, br_dir_pred, br_target_pred}.
REQ-016 ififo_count  out  log2(IFIFO_DEPTH)+1  occupied entries.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DRAIN, with at most one icache request outstanding.
REQ-018 IDLE SHALL last one cycle after rst deasserts, then go to REQ.
REQ-019 In REQ, icache_req_valid SHALL be 1 only when free entries >= FETCH_WIDTH; on valid&&ready the FSM SHALL go to WAIT.
REQ-020 In WAIT, on icache_resp_valid: enqueue the group, pc_q <= predicted next PC, go to REQ; the new request MAY issue in the following cycle.
REQ-021 Start slot SHALL be s = pc_q[log2(FETCH_WIDTH*4)-1:2]; slots below s SHALL be dropped.
REQ-022 Per slot, JAL SHALL be predicted taken; a cond branch (opcode 1100011) SHALL be predicted per REQ-033/034; all other instructions are not taken.
REQ-023 The group SHALL end at the first predicted-taken slot k >= s; next PC SHALL be pc_k + sign-extended imm; slots after k are dropped.
REQ-024 With no taken slot, next PC SHALL be group base + FETCH_WIDTH*4.
REQ-025 All PC arithmetic is 32-bit modulo 2^32; wrap from 0xFFFFFFF8 is legal.
REQ-026 Each enqueued entry: pc = base + 4*i; br_target_pred = the next PC if that slot ends the group, else pc + 4; is_cond_br and br_dir_pred per slot.
REQ-027 The FIFO SHALL enqueue up to FETCH_WIDTH entries and dequeue 1 entry per cycle, in program order; enqueue and dequeue in the same cycle SHALL be allowed; pointers wrap modulo IFIFO_DEPTH.
REQ-028 On fetch_redirect_valid:
- pc_q <= fetch_redirect_PC;
- FIFO flushed (flush has priority over same-cycle enqueue and dequeue);
- ififo_dispatch_valid = 0 that cycle;
- IDLE/REQ go to REQ; WAIT goes to DRAIN; DRAIN stays in DRAIN.
REQ-029 In DRAIN, icache_resp_valid SHALL be discarded and the FSM SHALL go to REQ.
REQ-030 A redirect in WAIT coinciding with icache_resp_valid SHALL discard the response and go to REQ.

Reset
REQ-031 rst SHALL, on the next clk edge, set:
- state = IDLE;
- pc_q = RESET_PC;
- FIFO empty, ififo_count = 0;
- icache_req_valid = 0, ififo_dispatch_valid = 0.
REQ-032 rst asserted mid-WAIT SHALL abandon the outstanding request; any icache_resp_valid seen while in IDLE SHALL be ignored.

Configuration
REQ-033 With IFU_BTFN_PRED_EN defined, a cond branch with a negative offset SHALL be predicted taken and one with a positive offset not taken.
REQ-034 With IFU_BTFN_PRED_EN undefined, all cond branches SHALL be predicted not taken, with br_dir_pred = 0; JAL is unaffected.

Verification
REQ-035 Bench SHALL cover (FETCH_WIDTH=2, IFIFO_DEPTH=8 unless stated):
- rst released, RESET_PC=0x0 -> IDLE one cycle, then icache_req_valid=1 with addr 0x0;
- pc_q=0x4 with two ADDI -> only slot 1 enqueued (count +1, pc 0x4), next req addr 0x8;
- JAL +16 at 0x10 -> one entry, br_target_pred 0x20, next req addr 0x20;
- redirect to 0x100 in WAIT -> FIFO empty, next-cycle resp discarded, then req addr 0x100;
- count=7 -> req_valid stays 0 until one dequeue brings count to 6;
- BNE at 0x40, offset -8 -> with IFU_BTFN_PRED_EN next req 0x38; without it 0x48.
